// File: rtl/fdiv_iterative.sv
// Radix-2 restoring divider for unpacked single-precision significands: one quotient
// bit per cycle, truncated mantissa, exponent rebias and zero/overflow/underflow flags.
module fdiv_iterative #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_1,
    input  logic [MAN_W-1:0] man_1,
    input  logic [EXP_W-1:0] exp_2,
    input  logic [MAN_W-1:0] man_2,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] final_exp,
    output logic [MAN_W-1:0] final_man,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             underflow
);
    localparam int SIG_W = MAN_W + 1;
    localparam int REM_W = MAN_W + 3;
    localparam int Q_W   = MAN_W + 2;
    localparam int EZ_W  = EXP_W + 2;
    localparam int CNT_W = $clog2(Q_W);
    localparam logic signed [EZ_W-1:0] EMAX = EZ_W'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

    state_t                 state_q;
    logic [REM_W-1:0]       rem_q;
    logic [SIG_W-1:0]       den_q;
    logic [Q_W-1:0]         quo_q;
    logic [CNT_W-1:0]       cnt_q;
    logic signed [EZ_W-1:0] ez_q;
    logic                   zd_q, zs_q;

    logic [SIG_W-1:0]       sig_1, sig_2;
    logic [EZ_W-1:0]        ez_start;
    logic [REM_W-1:0]       den_ext, rem_d;
    logic                   ge;
    logic signed [EZ_W-1:0] e_d;
    logic [MAN_W-1:0]       man_d;

    // Zero exponent flushes the operand to zero (no denormals).
    assign sig_1    = (exp_1 != '0) ? {1'b1, man_1} : '0;
    assign sig_2    = (exp_2 != '0) ? {1'b1, man_2} : '0;
    assign ez_start = EZ_W'(exp_1) - EZ_W'(exp_2) + EZ_W'(BIAS);

    assign den_ext = REM_W'(den_q);
    assign ge      = rem_q >= den_ext;
    assign rem_d   = ge ? ((rem_q - den_ext) << 1) : (rem_q << 1);

    // Quotient lies in (0.5, 2): a leading one in the top bit means no renormalisation.
    assign e_d   = quo_q[Q_W-1] ? ez_q : ez_q - {{(EZ_W-1){1'b0}}, 1'b1};
    assign man_d = quo_q[Q_W-1] ? quo_q[Q_W-2:1] : quo_q[Q_W-3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            ez_q        <= '0;
            zd_q        <= 1'b0;
            zs_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            final_exp   <= '0;
            final_man   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    rem_q       <= REM_W'(sig_1);
                    den_q       <= sig_2;
                    quo_q       <= '0;
                    cnt_q       <= CNT_W'(MAN_W + 1);
                    ez_q        <= ez_start;
                    zd_q        <= (exp_1 == '0);
                    zs_q        <= (exp_2 == '0);
                    busy        <= 1'b1;
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    underflow   <= 1'b0;
                    state_q     <= DIV;
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= {quo_q[Q_W-2:0], ge};
                    if (cnt_q == '0) state_q <= NORM;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                NORM: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= DONE;
                    if (zs_q) begin
                        final_exp   <= '1;
                        final_man   <= '0;
                        div_by_zero <= 1'b1;
                    end else if (zd_q) begin
                        final_exp <= '0;
                        final_man <= '0;
                    end else if (e_d >= EMAX) begin
                        final_exp <= '1;
                        final_man <= '0;
                        overflow  <= 1'b1;
                    end else if (e_d[EZ_W-1] || e_d == '0) begin
                        final_exp <= '0;
                        final_man <= '0;
                        underflow <= 1'b1;
                    end else begin
                        final_exp <= e_d[EXP_W-1:0];
                        final_man <= man_d;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
